// File: rtl/rr_grant_pkg.sv
// Shared definitions for the round-robin grant controller.
//   NUM_REQ / IDX_W : requester count and index width
//   state_t         : controller FSM states
//   onehot_from_idx : binary index -> one-hot grant vector
package rr_grant_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Circular first-set search over the request vector starting at ptr.
// Ports:
//   req     [3:0] in  request vector
//   ptr     [1:0] in  highest-priority position for this search
//   sel     [1:0] out index of the selected requester (0 when no request)
//   any_req       out at least one request bit is set
module rr_select
    import rr_grant_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   first;

    // Rotate so that position ptr lands at bit 0.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot[IDX_W'(i)] = req[IDX_W'(i + ptr)];
        end
    end

    // Fixed-priority encode; scanning downwards leaves the lowest set bit.
    always_comb begin
        first = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (rot[IDX_W'(i - 1)]) begin
                first = IDX_W'(i - 1);
            end
        end
    end

    // Un-rotate back into absolute requester numbering (2-bit wrap).
    assign sel     = first + ptr;
    assign any_req = |req;

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter sharing one 4-way resource between four requesters.
// A grant is held until the owner signals done, drops its request, or the
// hold counter expires (forced release with a one-cycle timeout pulse).
// Ports:
//   clk             in  system clock, rising edge
//   rst             in  synchronous active-high reset
//   en              in  enables new grants (does not affect an active grant)
//   req       [3:0] in  request vector
//   done            in  owner finished; only looked at while busy
//   grant     [3:0] out one-hot grant, zero when idle
//   grant_idx [1:0] out index of current/last owner
//   busy            out grant active
//   timeout         out one-cycle pulse on forced release
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [IDX_W-1:0] sel;
    logic             any_req;
    logic             req_drop;
    logic             expired;
    logic             release_now;

    rr_select u_select (
        .req     (req),
        .ptr     (ptr),
        .sel     (sel),
        .any_req (any_req)
    );

    assign req_drop    = ~req[grant_idx];
    assign expired     = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = done | req_drop | expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        state     <= GRANT;
                        grant_idx <= sel;
                        grant     <= onehot_from_idx(sel);
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        ptr     <= grant_idx + 1'b1;
                        // Done or a dropped request wins over simultaneous expiry.
                        timeout <= expired & ~done & ~req_drop;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one 4-way resource between four requesters.
- Selects one requester and drives a 2-bit grant index plus a one-hot grant vector with enable.
- Holds the grant until the owner signals completion, drops its request, or a hold timeout expires.
- Sits between requester logic and the shared resource's select/enable inputs.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; gates new grants only.
- req  input  4  request vector, bit i = requester i.
- done  input  1  current owner finished; sampled only while busy.
- grant  output  4  one-hot grant; all zero when idle.
- grant_idx  output  2  binary index of current owner; holds last value when idle.
- busy  output  1  high while a grant is active.
- timeout  output  1  single-cycle pulse on forced release.

Behaviour:
- Reset, synchronous, priority over everything: state=IDLE, ptr=0, grant=4'b0000, grant_idx=0, busy=0, timeout=0, hold_cnt=0.
- Reset asserted mid-grant drops the grant on the next edge; no timeout pulse is generated.
- FSM states: IDLE, GRANT. All outputs are registered.

IDLE state:
- If en=1 and req!=0, select the first set req bit scanning circularly from ptr (ptr, ptr+1, ... mod 4).
- On the next edge: grant_idx=sel, grant=one-hot(sel), busy=1, hold_cnt=0, go to GRANT.
- Latency: req sampled in cycle N, grant visible in cycle N+1.
- If en=0 or req=0, stay in IDLE with outputs unchanged. done is ignored in IDLE.

GRANT state:
- hold_cnt increments each cycle.
- Release condition: done=1, or req[grant_idx]=0, or hold_cnt==MAX_HOLD-1.
- On release, at the next edge: grant=0, busy=0, ptr=grant_idx+1 (2-bit wrap, so 3 wraps to 0), go to IDLE.
- Minimum one idle cycle between consecutive grants; no back-to-back handover.
- timeout=1 for exactly one cycle, concurrent with the release edge, only when the counter expired and neither done nor request-drop was present that same cycle.
- Simultaneous done and counter expiry: treated as normal completion, no timeout pulse.
- en deasserted during GRANT does not affect the current grant.
- Requests from other requesters during GRANT are ignored until IDLE.

Invariants:
- grant is either zero or one-hot, and equals one-hot(grant_idx) whenever busy=1.
- busy == (grant != 0).

Fairness:
- Each requester is served at most once per four consecutive grants while all four request continuously.
- Grant order is then 0,1,2,3,0,...

Decomposition:
- Shared package rr_grant_pkg holds:
  - NUM_REQ=4 and IDX_W=2 constants.
  - State enum typedef {IDLE, GRANT}.
  - A one-hot-from-index function.
- One combinational sub-module, rr_select: inputs req[3:0] and ptr[1:0]; outputs sel[1:0] and any_req.
  - Implemented as a rotate, then a fixed-priority encode, then an un-rotate.
- Top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
1. Reset and basic grant: rst high 2 cycles, check all outputs 0. Then en=1, req=4'b0100 at cycle N → cycle N+1 grant=4'b0100, grant_idx=2, busy=1. done pulse at cycle N+3 → cycle N+4 grant=0, busy=0, ptr=3.
2. Round-robin: en=1, req=4'b1111 held; pulse done 2 cycles after each grant → grant_idx sequence 0,1,2,3,0 with one idle cycle between grants.
3. Timeout: MAX_HOLD=16, req=4'b0001, never assert done → grant held 16 cycles. Release edge shows timeout=1 for one cycle, grant=0, busy=0. Next grant goes to idx 0 again since it is the only requester.
4. Done/timeout collision: assert done exactly in the expiry cycle → release occurs, timeout stays 0.
5. Request drop and enable: during a grant to idx 1, deassert req[1] → release next edge, ptr=2. With en=0 and req=4'b1111 in IDLE → no grant for 10 cycles. en=1 → grant_idx=2.
6. Reset mid-grant: rst=1 while busy with grant_idx=3 → next edge all outputs 0, ptr=0, no timeout pulse. With req=4'b1010 after reset → grant_idx=1.
